// File: rtl/id_pkg.sv
// rtl/id_pkg.sv - shared instruction encodings and fetch FSM states
package id_pkg;

  typedef enum logic [3:0] {
    NOP   = 4'h0,
    LOAD  = 4'h1,
    STORE = 4'h2,
    ADD   = 4'h3,
    HALT  = 4'hF
  } cpu_instructions;

  localparam logic [15:0] NOP_WORD = {NOP, 12'h000};

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_ISSUE,
    S_HALT
  } fetch_state_t;

endpackage

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - program counter sequencer feeding instruction_decoder
module instruction_fetch
  import id_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              imem_re,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_rdata,
  output logic [15:0]       instruction,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic [15:0]       instr_count
);

  localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC);

  fetch_state_t state, state_next;
  logic [15:0]  instr_reg;
  logic         xfer;
  logic         is_halt_op;

  assign xfer       = (state == S_ISSUE) && instr_ready;
  assign is_halt_op = (cpu_instructions'(instr_reg[15:12]) == HALT);

  // All outputs decode from state and registers only, never from inputs.
  assign imem_re     = (state == S_FETCH);
  assign imem_addr   = pc;
  assign instr_valid = (state == S_ISSUE);
  assign halted      = (state == S_HALT);
  assign instruction = (state == S_ISSUE) ? instr_reg : NOP_WORD;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      pc          <= PC_INIT;
      instr_reg   <= NOP_WORD;
      instr_count <= 16'h0000;
    end else begin
      state <= state_next;
      if (state == S_WAIT) begin
        instr_reg <= imem_rdata;
      end
      if (xfer) begin
        pc          <= pc + 1'b1;
        instr_count <= instr_count + 16'h0001;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_FETCH;
      S_FETCH: state_next = S_WAIT;
      S_WAIT:  state_next = S_ISSUE;
      S_ISSUE: if (instr_ready) state_next = is_halt_op ? S_HALT : S_FETCH;
      S_HALT:  if (start) state_next = S_FETCH;
      default: state_next = S_IDLE;
    endcase
  end

endmodule
